ring_counter_ctrl: RTL and testbench

Step scheduler and configuration controller for the user-area ring counter. It paces advance pulses through a programmable prescaler and runs free-running, N-step burst or seeded sequences. It owns direction, seed load and pad output-enable, and sits between the caravel-side register/trigger logic and the `ring_counter` instance inside `user_project_wrapper`.

---
 rtl/ring_counter_ctrl_if.sv | 11 +
 rtl/ring_counter_ctrl.sv | 133 +++++++++++++
 tb/tb_ring_counter_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ring_counter_ctrl_if.sv
// Configuration write channel for ring_counter_ctrl: valid/ready handshake
// carrying a 2-bit register address and 16-bit LSB-aligned write data.
interface ring_counter_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;

  modport master (output cfg_valid, output cfg_addr, output cfg_wdata, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_wdata, output cfg_ready);
endinterface

// File: rtl/ring_counter_ctrl.sv
// Step scheduler for the user-area ring counter: prescaled advance pulses,
// free-run / N-step burst sequencing, seed load strobe and pad output-enable.
module ring_counter_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  ring_counter_ctrl_if.slave cfg,
  input  logic             start,
  input  logic             stop,
  output logic             step_en,
  output logic             dir,
  output logic             load,
  output logic [WIDTH-1:0] load_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] io_oeb
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] ADDR_DIV   = 2'd0;
  localparam logic [1:0] ADDR_BURST = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;
  localparam logic [1:0] ADDR_SEED  = 2'd3;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] burst_q;
  logic [DIV_W-1:0] presc_q;
  logic [CNT_W-1:0] steps_left_q;
  logic             oe_q;
  logic             cfg_wr;
  logic             step_fire;
  logic             run_start;

  assign cfg.cfg_ready = (state_q == S_IDLE) || (cfg.cfg_addr == ADDR_CTRL);
  assign cfg_wr        = cfg.cfg_valid && cfg.cfg_ready;

  assign busy   = (state_q == S_RUN);
  assign load   = (state_q == S_LOAD);
  assign done   = (state_q == S_DONE);
  assign io_oeb = {WIDTH{~oe_q}};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // In burst mode the final step leaves steps_left at 0 while still in RUN;
  // DONE is entered one edge later so done follows the last step_en.
  always_comb begin
    state_d   = state_q;
    step_fire = 1'b0;
    run_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_wr && (cfg.cfg_addr == ADDR_SEED)) begin
          state_d = S_LOAD;
        end else if (start && !stop) begin
          state_d   = S_RUN;
          run_start = 1'b1;
        end
      end
      S_LOAD: state_d = S_IDLE;
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if ((burst_q != '0) && (steps_left_q == '0)) begin
          state_d = S_DONE;
        end else if (presc_q == div_q) begin
          step_fire = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      div_q    <= '0;
      burst_q  <= '0;
      dir      <= 1'b0;
      oe_q     <= 1'b0;
      load_val <= WIDTH'(1);
    end else if (cfg_wr) begin
      case (cfg.cfg_addr)
        ADDR_DIV:   div_q    <= cfg.cfg_wdata[DIV_W-1:0];
        ADDR_BURST: burst_q  <= cfg.cfg_wdata[CNT_W-1:0];
        ADDR_CTRL: begin
          dir  <= cfg.cfg_wdata[0];
          oe_q <= cfg.cfg_wdata[1];
        end
        default:    load_val <= cfg.cfg_wdata[WIDTH-1:0];
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      presc_q      <= '0;
      steps_left_q <= '0;
      step_en      <= 1'b0;
    end else begin
      step_en <= step_fire;
      if (run_start) begin
        presc_q      <= '0;
        steps_left_q <= burst_q;
      end else if (state_q == S_RUN) begin
        if (step_fire) begin
          presc_q <= '0;
          if (burst_q != '0) begin
            steps_left_q <= steps_left_q - 1'b1;
          end
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ring_counter_ctrl.sv
// Self-checking bench for ring_counter_ctrl: CTRL vector table, directed corner
// sequences and randomized runs checked against an arithmetic timing model.
module tb_ring_counter_ctrl;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       step_en, dir, load, busy, done;
  logic [3:0] load_val, io_oeb;

  int checks = 0;
  int errors = 0;
  logic exp_dir = 1'b0;
  logic exp_oe  = 1'b0;

  ring_counter_ctrl_if cfg ();

  ring_counter_ctrl #(.WIDTH(4), .DIV_W(16), .CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .cfg(cfg.slave),
    .start(start), .stop(stop), .step_en(step_en), .dir(dir), .load(load),
    .load_val(load_val), .busy(busy), .done(done), .io_oeb(io_oeb)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] wdata;
    logic        exp_dir;
    logic [3:0]  exp_oeb;
  } ctrl_vec_t;

  ctrl_vec_t ctrl_tab[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge Clock);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_addr  = a;
    cfg.cfg_wdata = d;
    #1;
    while (!cfg.cfg_ready && n < 200) begin
      @(negedge Clock);
      #1;
      n++;
    end
    if (n >= 200) check("cfg_write_timeout", 32'd0, 32'd1);
    @(posedge Clock);
    #1;
    cfg.cfg_valid = 1'b0;
  endtask

  // Expected behaviour of a run started at edge E0, with cycle c = the interval
  // after edge E0+c. Steps fall on multiples of DIV+1; stop sampled at edge s.
  task automatic run_check(input int d, input int n, input int s, input int w, input logic [1:0] wd);
    int p = d + 1;
    int t = n * p;
    int maxc = (n == 0) ? s + 2 : t + 3;
    logic e_step, e_busy, e_done;
    @(negedge Clock);
    start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    for (int c = 0; c <= maxc; c++) begin
      if (c > 0) begin
        if (c == s) stop = 1'b1;
        if (c == w) begin
          cfg.cfg_valid = 1'b1;
          cfg.cfg_addr  = 2'd2;
          cfg.cfg_wdata = {14'd0, wd};
        end
        @(posedge Clock);
        #1;
        stop = 1'b0;
        if (c == w) begin
          cfg.cfg_valid = 1'b0;
          exp_dir = wd[0];
          exp_oe  = wd[1];
        end
      end
      e_step = (c >= 1) && (c % p == 0) && (n == 0 || c / p <= n) && (s == 0 || c < s);
      e_busy = (n == 0 || c <= t) && (s == 0 || c < s);
      e_done = (n != 0) && (c == t + 1) && (s == 0 || s > t + 1);
      check($sformatf("run d=%0d n=%0d s=%0d c=%0d {step,busy,done}", d, n, s, c),
            {29'd0, step_en, busy, done}, {29'd0, e_step, e_busy, e_done});
      check($sformatf("run d=%0d n=%0d c=%0d {dir,io_oeb}", d, n, c),
            {27'd0, dir, io_oeb}, {27'd0, exp_dir, {4{~exp_oe}}});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int steps;
    int stall;
    int d, n, s, w, t;

    ctrl_tab[0] = '{16'h0001, 1'b1, 4'b1111};
    ctrl_tab[1] = '{16'h0002, 1'b0, 4'b0000};
    ctrl_tab[2] = '{16'h0003, 1'b1, 4'b0000};
    ctrl_tab[3] = '{16'hFFFE, 1'b0, 4'b0000};
    ctrl_tab[4] = '{16'hFFFD, 1'b1, 4'b1111};
    ctrl_tab[5] = '{16'h0000, 1'b0, 4'b1111};

    cfg.cfg_valid = 1'b0;
    cfg.cfg_addr  = 2'd0;
    cfg.cfg_wdata = 16'd0;

    // Reset values
    #2 Reset = 1'b0;
    #20;
    check("reset {step,load,done,busy}", {28'd0, step_en, load, done, busy}, 32'd0);
    check("reset cfg_ready", {31'd0, cfg.cfg_ready}, 32'd1);
    check("reset io_oeb", {28'd0, io_oeb}, 32'hF);
    check("reset load_val", {28'd0, load_val}, 32'h1);
    check("reset dir", {31'd0, dir}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    // CTRL register vectors
    foreach (ctrl_tab[i]) begin
      cfg_write(2'd2, ctrl_tab[i].wdata);
      check($sformatf("ctrl[%0d] dir", i), {31'd0, dir}, {31'd0, ctrl_tab[i].exp_dir});
      check($sformatf("ctrl[%0d] io_oeb", i), {28'd0, io_oeb}, {28'd0, ctrl_tab[i].exp_oeb});
    end
    exp_dir = 1'b0;
    exp_oe  = 1'b0;

    // Burst DIV=3 BURST=4
    cfg_write(2'd0, 16'd3);
    cfg_write(2'd1, 16'd4);
    run_check(3, 4, 0, 0, 2'd0);

    // Free-run DIV=0 with stop
    cfg_write(2'd0, 16'd0);
    cfg_write(2'd1, 16'd0);
    run_check(0, 0, 6, 0, 2'd0);

    // CTRL write mid-burst keeps cadence
    cfg_write(2'd0, 16'd3);
    cfg_write(2'd1, 16'd4);
    run_check(3, 4, 0, 6, 2'd3);
    cfg_write(2'd2, 16'd0);
    exp_dir = 1'b0;
    exp_oe  = 1'b0;

    // Seed load
    cfg_write(2'd3, 16'h0008);
    check("seed load", {31'd0, load}, 32'd1);
    check("seed load_val", {28'd0, load_val}, 32'h8);
    check("seed cfg_ready in LOAD", {31'd0, cfg.cfg_ready}, 32'd0);
    @(posedge Clock);
    #1;
    check("seed load one cycle", {31'd0, load}, 32'd0);
    check("seed cfg_ready after", {31'd0, cfg.cfg_ready}, 32'd1);
    check("seed load_val held", {28'd0, load_val}, 32'h8);

    // Seed write wins over start in the same cycle
    @(negedge Clock);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_addr  = 2'd3;
    cfg.cfg_wdata = 16'h0002;
    start = 1'b1;
    @(posedge Clock);
    #1;
    cfg.cfg_valid = 1'b0;
    start = 1'b0;
    check("seed+start load", {31'd0, load}, 32'd1);
    check("seed+start busy", {31'd0, busy}, 32'd0);
    check("seed+start load_val", {28'd0, load_val}, 32'h2);
    @(posedge Clock);
    #1;
    check("seed+start dropped", {30'd0, busy, load}, 32'd0);

    // start && stop together stays IDLE
    @(negedge Clock);
    start = 1'b1;
    stop  = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("start+stop c=%0d {step,busy,done}", c), {29'd0, step_en, busy, done}, 32'd0);
      @(posedge Clock);
      #1;
    end

    // DIV write stalls during a burst (DIV=1, BURST=3 -> IDLE at cycle 8)
    cfg_write(2'd0, 16'd1);
    cfg_write(2'd1, 16'd3);
    @(negedge Clock);
    start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_addr  = 2'd0;
    cfg.cfg_wdata = 16'd2;
    stall = 0;
    #1;
    while (!cfg.cfg_ready && stall < 100) begin
      @(posedge Clock);
      #1;
      stall++;
    end
    check("div stall cycles", stall, 32'd8);
    @(posedge Clock);
    #1;
    cfg.cfg_valid = 1'b0;
    run_check(2, 3, 0, 0, 2'd0);

    // Reset mid-burst, then a full restart
    cfg_write(2'd2, 16'd3);
    exp_dir = 1'b1;
    exp_oe  = 1'b1;
    cfg_write(2'd0, 16'd1);
    cfg_write(2'd1, 16'd10);
    @(negedge Clock);
    start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    steps = 0;
    for (int c = 0; c < 60 && steps < 3; c++) begin
      @(posedge Clock);
      #1;
      if (step_en) steps++;
    end
    check("midburst steps seen", steps, 32'd3);
    #2 Reset = 1'b0;
    #1;
    check("midreset {step,load,done,busy}", {28'd0, step_en, load, done, busy}, 32'd0);
    check("midreset io_oeb", {28'd0, io_oeb}, 32'hF);
    check("midreset dir", {31'd0, dir}, 32'd0);
    check("midreset load_val", {28'd0, load_val}, 32'h1);
    check("midreset cfg_ready", {31'd0, cfg.cfg_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge Clock);
      #1;
      check($sformatf("midreset hold c=%0d {done,busy}", c), {30'd0, done, busy}, 32'd0);
    end
    @(negedge Clock);
    Reset = 1'b1;
    exp_dir = 1'b0;
    exp_oe  = 1'b0;
    cfg_write(2'd0, 16'd1);
    cfg_write(2'd1, 16'd10);
    run_check(1, 10, 0, 0, 2'd0);

    // Randomized runs against the timing model
    for (int k = 0; k < 20; k++) begin
      d = $urandom_range(0, 4);
      n = $urandom_range(0, 5);
      t = n * (d + 1);
      if (n == 0) s = $urandom_range(1, 20);
      else if ($urandom_range(0, 1) == 1) s = $urandom_range(1, t + 2);
      else s = 0;
      w = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (n == 0) ? s : t) : 0;
      cfg_write(2'd0, 16'(d));
      cfg_write(2'd1, 16'(n));
      run_check(d, n, s, w, 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
